mips_regfile_mp: RTL and testbench

Parametrised multi-port register file for the MIPS datapath, successor to the single-write, dual-read file. It has a configurable data width, depth and read-port count, plus two write ports with fixed priority. Same-cycle write-to-read bypass is kept. A hardware clear sequencer zeroes every entry after reset or on request, so no entry ever reads as X.

---
 rtl/mips_regfile_mp.sv | 134 +++++++++++++
 tb/tb_mips_regfile_mp.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_regfile_mp.sv
// Multi-port MIPS register file: two prioritised write ports, NUM_RD combinational read ports
// with same-cycle write bypass, and a clear sequencer that zeroes every entry after reset or on request.
module mips_regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_req,
    output logic                     busy,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic                     wr_conflict
);

    localparam int              DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam bit              ZR    = (ZERO_REG != 0);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W-1:0]   clr_ptr_r;
    logic [ADDR_W-1:0]   clr_ptr_nxt_s;
    logic                busy_s;
    logic                eff0_s;
    logic                eff1_s;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    assign busy_s = (state_r == CLEAR);
    assign busy   = busy_s;

    // Writes are effective only in IDLE and never to the hardwired zero entry.
    assign eff0_s = we0 && !busy_s && !(ZR && (waddr0 == '0));
    assign eff1_s = we1 && !busy_s && !(ZR && (waddr1 == '0));

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= CLEAR;
            clr_ptr_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            clr_ptr_r <= clr_ptr_nxt_s;
        end
    end

    // Sequencer next state: a clear walks every entry once, clr_req only honoured in IDLE
    always_comb begin
        state_nxt_s   = state_r;
        clr_ptr_nxt_s = clr_ptr_r;
        case (state_r)
            IDLE: begin
                if (clr_req) begin
                    state_nxt_s   = CLEAR;
                    clr_ptr_nxt_s = '0;
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            CLEAR: begin
                if (clr_ptr_r == LAST) begin
                    state_nxt_s   = IDLE;
                    clr_ptr_nxt_s = '0;
                end else begin
                    clr_ptr_nxt_s = clr_ptr_r + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt_s   = CLEAR;
                clr_ptr_nxt_s = '0;
            end
        endcase
    end

    // Storage update; port 1 is applied last so it wins a same-address collision
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (busy_s) begin
                mem_r[clr_ptr_r] <= '0;
            end else begin
                if (eff0_s) mem_r[waddr0] <= wdata0;
                if (eff1_s) mem_r[waddr1] <= wdata1;
            end
        end
    end

    // Collision flag, one cycle after both ports hit the same entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_conflict <= 1'b0;
        end else begin
            wr_conflict <= eff0_s && eff1_s && (waddr0 == waddr1);
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra_s;
        logic [DATA_W-1:0] rd_s;

        assign ra_s = raddr[k*ADDR_W +: ADDR_W];

        // Read mux with bypass of this cycle's writes
        always_comb begin
            rd_s = '0;
            if (busy_s) begin
                rd_s = '0;
            end else if (ZR && (ra_s == '0)) begin
                rd_s = '0;
            end else if (eff1_s && (waddr1 == ra_s)) begin
                rd_s = wdata1;
            end else if (eff0_s && (waddr0 == ra_s)) begin
                rd_s = wdata0;
            end else begin
                rd_s = mem_r[ra_s];
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = rd_s;
    end

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Bench for mips_regfile_mp: a ZERO_REG=1 and a ZERO_REG=0 instance share stimulus and are
// compared every cycle against a behavioural model, plus literal expectations per scenario.
module tb_mips_regfile_mp;

    logic        clk;
    logic        rst;
    logic        clr_req;
    logic        we0, we1;
    logic [4:0]  waddr0, waddr1;
    logic [31:0] wdata0, wdata1;
    logic [9:0]  raddr;
    logic [63:0] rdata, rdata_nz;
    logic        busy, busy_nz;
    logic        wr_conflict, wr_conflict_nz;

    int n_chk = 0;
    int n_err = 0;
    int n;

    mips_regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata), .wr_conflict(wr_conflict)
    );

    mips_regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0)) dut_nz (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_nz),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_nz), .wr_conflict(wr_conflict_nz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: remaining clear cycles, contents of each instance, expected conflict flags.
    int          m_busy = 32;
    logic [31:0] mm [32];
    logic [31:0] mn [32];
    logic        m_conf = 1'b0;
    logic        m_conf_nz = 1'b0;
    logic        check_en = 1'b0;

    function automatic logic eff(input logic we, input logic [4:0] a, input logic zr);
        return we && !(zr && a == 5'd0);
    endfunction

    function automatic logic [31:0] exp_rd(input logic zr, input logic [4:0] a);
        if (m_busy > 0) return 32'h0;
        if (zr && a == 5'd0) return 32'h0;
        if (eff(we1, waddr1, zr) && waddr1 == a) return wdata1;
        if (eff(we0, waddr0, zr) && waddr0 == a) return wdata0;
        return zr ? mm[a] : mn[a];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy    <= 32;
            m_conf    <= 1'b0;
            m_conf_nz <= 1'b0;
        end else if (m_busy > 0) begin
            m_busy    <= m_busy - 1;
            m_conf    <= 1'b0;
            m_conf_nz <= 1'b0;
            if (m_busy == 1) begin
                for (int a = 0; a < 32; a++) begin
                    mm[a] <= 32'h0;
                    mn[a] <= 32'h0;
                end
            end
        end else begin
            if (clr_req) m_busy <= 32;
            if (eff(we1, waddr1, 1'b1)) mm[waddr1] <= wdata1;
            if (eff(we0, waddr0, 1'b1) && !(eff(we1, waddr1, 1'b1) && waddr0 == waddr1)) mm[waddr0] <= wdata0;
            if (eff(we1, waddr1, 1'b0)) mn[waddr1] <= wdata1;
            if (eff(we0, waddr0, 1'b0) && !(eff(we1, waddr1, 1'b0) && waddr0 == waddr1)) mn[waddr0] <= wdata0;
            m_conf    <= eff(we0, waddr0, 1'b1) && eff(we1, waddr1, 1'b1) && waddr0 == waddr1;
            m_conf_nz <= eff(we0, waddr0, 1'b0) && eff(we1, waddr1, 1'b0) && waddr0 == waddr1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("cmp_busy",    {31'd0, busy},           {31'd0, m_busy > 0});
            chk("cmp_busy_nz", {31'd0, busy_nz},        {31'd0, m_busy > 0});
            chk("cmp_conf",    {31'd0, wr_conflict},    {31'd0, m_conf});
            chk("cmp_conf_nz", {31'd0, wr_conflict_nz}, {31'd0, m_conf_nz});
            chk("cmp_rd0",     rdata[31:0],     exp_rd(1'b1, raddr[4:0]));
            chk("cmp_rd1",     rdata[63:32],    exp_rd(1'b1, raddr[9:5]));
            chk("cmp_rd0_nz",  rdata_nz[31:0],  exp_rd(1'b0, raddr[4:0]));
            chk("cmp_rd1_nz",  rdata_nz[63:32], exp_rd(1'b0, raddr[9:5]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(input string name);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk(name, n, 32);
    endtask

    task automatic read_all_zero(input string name);
        for (int a = 0; a < 32; a++) begin
            raddr = {5'(31 - a), 5'(a)};
            #2;
            chk(name, rdata[31:0] | rdata[63:32] | rdata_nz[31:0] | rdata_nz[63:32], 32'h0);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; clr_req = 1'b0;
        we0 = 1'b0; we1 = 1'b0; waddr0 = 5'd0; waddr1 = 5'd0;
        wdata0 = 32'h0; wdata1 = 32'h0; raddr = 10'd0;
        #1 check_en = 1'b1;
        repeat (3) tick();
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_conf", {31'd0, wr_conflict}, 32'd0);
        chk("rst_rdata", rdata[31:0] | rdata[63:32], 32'h0);
        rst = 1'b0;
        count_busy("reset_clear_len");
        read_all_zero("reset_clear_zero");

        // write with bypass on both read ports
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; raddr = {5'd5, 5'd5};
        #2 chk("bypass_rd0", rdata[31:0], 32'hDEADBEEF);
        chk("bypass_rd1", rdata[63:32], 32'hDEADBEEF);
        tick();
        we0 = 1'b0;
        #2 chk("stored_rd0", rdata[31:0], 32'hDEADBEEF);
        tick();
        chk("stored_rd0_later", rdata[31:0], 32'hDEADBEEF);

        // dual-write collision
        we0 = 1'b1; we1 = 1'b1; waddr0 = 5'd7; waddr1 = 5'd7;
        wdata0 = 32'h11111111; wdata1 = 32'h22222222; raddr = {5'd5, 5'd7};
        #2 chk("coll_bypass", rdata[31:0], 32'h22222222);
        tick();
        we0 = 1'b0; we1 = 1'b0;
        #2 chk("coll_conf", {31'd0, wr_conflict}, 32'd1);
        chk("coll_mem", rdata[31:0], 32'h22222222);
        tick();
        chk("coll_conf_once", {31'd0, wr_conflict}, 32'd0);

        // zero register on both instances
        we0 = 1'b1; we1 = 1'b1; waddr0 = 5'd0; waddr1 = 5'd0;
        wdata0 = 32'hFFFFFFFF; wdata1 = 32'hFFFFFFFF; raddr = {5'd0, 5'd0};
        #2 chk("zr_bypass", rdata[31:0], 32'h0);
        chk("nz_bypass", rdata_nz[31:0], 32'hFFFFFFFF);
        tick();
        we0 = 1'b0; we1 = 1'b0;
        #2 chk("zr_read", rdata[63:32], 32'h0);
        chk("zr_conf", {31'd0, wr_conflict}, 32'd0);
        chk("nz_read", rdata_nz[63:32], 32'hFFFFFFFF);
        chk("nz_conf", {31'd0, wr_conflict_nz}, 32'd1);
        tick();

        // fill, then soft clear with clr_req held and writes attempted during busy
        for (int a = 1; a < 32; a++) begin
            we0 = a[0]; we1 = !a[0];
            waddr0 = 5'(a); waddr1 = 5'(a);
            wdata0 = 32'hA5000000 | 32'(a); wdata1 = 32'h5A000000 | 32'(a);
            raddr = {5'(a), 5'(a - 1)};
            tick();
        end
        we0 = 1'b0; we1 = 1'b0; raddr = {5'd30, 5'd9};
        #2 chk("fill_rd0", rdata[31:0], 32'hA5000009);
        chk("fill_rd1", rdata[63:32], 32'h5A00001E);
        clr_req = 1'b1;
        tick();
        chk("soft_busy", {31'd0, busy}, 32'd1);
        we0 = 1'b1; we1 = 1'b1; waddr0 = 5'd3; waddr1 = 5'd4;
        wdata0 = 32'h12345678; wdata1 = 32'h9ABCDEF0;
        count_busy("soft_clear_len");
        clr_req = 1'b0; we0 = 1'b0; we1 = 1'b0;
        read_all_zero("soft_clear_zero");

        // reset in the middle of a clear
        we1 = 1'b1; waddr1 = 5'd12; wdata1 = 32'hCAFEF00D;
        tick();
        we1 = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        #2 chk("midclr_busy", {31'd0, busy}, 32'd1);
        tick();
        tick();
        rst = 1'b0;
        count_busy("midclr_len");
        read_all_zero("midclr_zero");

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
